button_cmd_sched: RTL and testbench
===================================

BUTTON_CMD_SCHED -- requirements
Module: button_cmd_sched

Interface
REQ-001 Parameter GATE_VBLANK, default 1: when 1, commands are only started while vblank=1; when 0, vblank is ignored.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 btn_pulse  input  4  one-cycle event pulses from the per-button debouncers; bit i = button i.
REQ-005 vblank  input  1  level from the VGA timing generator; 1 during vertical blanking.
REQ-006 cmd_ready  input  1  downstream (cursor/pattern logic) accepts the offered command.
REQ-007 cmd_valid  output  1  a command is offered.
REQ-008 cmd_id  output  2  index of the button whose command is offered.
REQ-009 pending  output  4  registered pending-request vector (debug/status).
REQ-010 overrun_cnt  output  8  saturating count of events lost to an already-pending request.

Function
REQ-011 The block SHALL hold a registered 4-bit pending vector: pending[i] sets on the edge after btn_pulse[i]=1 and clears only on acceptance of command i.
REQ-012 Multiple btn_pulse bits asserted in the same cycle SHALL each set their own pending bit; none are lost.
REQ-013 The FSM SHALL have exactly two states: IDLE and OFFER; reset state IDLE.
REQ-014 IDLE -> OFFER SHALL occur when pending != 0 and gate_ok, where gate_ok = vblank or GATE_VBLANK=0; the transition edge also loads cmd_id with the arbitration winner.
REQ-015 Arbitration SHALL be round-robin: winner = first index with pending set, searching rr_ptr, rr_ptr+1, ... modulo 4.
REQ-016 cmd_valid SHALL be 1 exactly when state=OFFER, driven from registers.
REQ-017 In OFFER, cmd_valid and cmd_id SHALL stay stable until cmd_valid&cmd_ready, regardless of vblank, new pulses or pending changes.
REQ-018 On the handshake edge: pending[cmd_id] clears, rr_ptr <= cmd_id+1 (2-bit wrap, 3 -> 0), state <= IDLE.
REQ-019 Throughput SHALL be at most one command per 2 cycles; cmd_valid SHALL be 0 for at least one cycle after each handshake.
REQ-020 Latency: pulse at cycle N with gate_ok true at N+1 and FSM idle SHALL give cmd_valid=1 in cycle N+2.
REQ-021 A btn_pulse[i] arriving while pending[i]=1 and not cleared in the same cycle SHALL leave pending[i]=1 and increment overrun_cnt.
REQ-022 A btn_pulse[i] in the same cycle as handshake of command i SHALL leave pending[i]=1 and SHALL NOT increment overrun_cnt.
REQ-023 overrun_cnt SHALL saturate at 255; multiple simultaneous overruns in one cycle SHALL add their count (1-4), clamped at 255.
REQ-024 If gate_ok is false in IDLE, pending requests SHALL accumulate and no command starts until gate_ok becomes true.

Reset
REQ-025 rst=1 at a rising edge SHALL set state=IDLE, pending=0, rr_ptr=0, cmd_valid=0, cmd_id=0, overrun_cnt=0, overriding all other inputs that cycle.
REQ-026 rst asserted during OFFER SHALL abort the offer with no handshake; the command is dropped and cmd_valid=0 on the next cycle.
REQ-027 btn_pulse asserted in a reset cycle SHALL be discarded.

Verification
REQ-028 vblank=1, cmd_ready=1, btn_pulse=4'b0100 for one cycle at N -> cmd_valid=1, cmd_id=2 at N+2; pending=0 and cmd_valid=0 at N+3.
REQ-029 vblank=1, cmd_ready=1, btn_pulse=4'b1111 for one cycle from reset -> cmd_id sequence 0,1,2,3, one every 2 cycles; overrun_cnt=0.
REQ-030 vblank=0, btn_pulse[1] three times, then vblank=1 -> exactly one command with cmd_id=1; overrun_cnt=2.
REQ-031 cmd_ready=0 for 10 cycles during OFFER with cmd_id=0, while toggling vblank and pulsing btn 3 -> cmd_valid and cmd_id=0 stable; cmd_id=3 is offered next after ready.
REQ-032 Pulse btn 2 in the same cycle as handshake of cmd_id=2 -> pending[2] stays 1; overrun_cnt unchanged; cmd_id=2 offered again.
REQ-033 rst pulse during OFFER -> next cycle cmd_valid=0, pending=0, overrun_cnt=0; 300 overrun events afterwards -> overrun_cnt=255.

Source files
------------

// File: rtl/button_cmd_sched_if.sv
// rtl/button_cmd_sched_if.sv - command offer/accept handshake between scheduler and cursor/pattern logic
interface button_cmd_sched_if;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       cmd_ready;

  // Scheduler side: offers a command, sees acceptance
  modport master (
    output cmd_valid,
    output cmd_id,
    input  cmd_ready
  );

  // Consumer side: sees the offer, accepts it
  modport slave (
    input  cmd_valid,
    input  cmd_id,
    output cmd_ready
  );
endinterface

// File: rtl/button_cmd_sched.sv
// rtl/button_cmd_sched.sv - round-robin scheduler turning button pulses into vblank-gated commands
module button_cmd_sched #(
  parameter bit GATE_VBLANK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            btn_pulse,
  input  logic                  vblank,
  output logic [3:0]            pending,
  output logic [7:0]            overrun_cnt,
  button_cmd_sched_if.master    cmd
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t     state;
  logic [1:0] rr_ptr;
  logic       offer_valid;
  logic [1:0] offer_id;

  logic       gate_ok;
  logic       handshake;
  logic [3:0] clr_mask;
  logic [3:0] lost;
  logic [2:0] lost_cnt;
  logic [8:0] ovr_sum;
  logic [7:0] ovr_next;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;

  assign cmd.cmd_valid = offer_valid;
  assign cmd.cmd_id    = offer_id;

  assign gate_ok   = vblank || (GATE_VBLANK == 1'b0);
  assign handshake = offer_valid && cmd.cmd_ready;

  // A request being accepted this cycle is not "already pending" for a same-cycle pulse
  assign clr_mask = handshake ? (4'b0001 << offer_id) : 4'b0000;
  assign lost     = btn_pulse & pending & ~clr_mask;
  assign lost_cnt = {2'b00, lost[0]} + {2'b00, lost[1]} + {2'b00, lost[2]} + {2'b00, lost[3]};
  assign ovr_sum  = {1'b0, overrun_cnt} + {6'b000000, lost_cnt};
  assign ovr_next = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];

  // Round-robin pick: first pending index starting at rr_ptr, wrapping modulo 4
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Two-state offer FSM plus pending/overrun bookkeeping, all registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= 4'b0000;
      rr_ptr      <= 2'd0;
      offer_valid <= 1'b0;
      offer_id    <= 2'd0;
      overrun_cnt <= 8'd0;
    end else begin
      pending     <= (pending & ~clr_mask) | btn_pulse;
      overrun_cnt <= ovr_next;
      case (state)
        IDLE: begin
          if ((pending != 4'b0000) && gate_ok) begin
            state       <= OFFER;
            offer_valid <= 1'b1;
            offer_id    <= winner;
          end
        end
        OFFER: begin
          if (cmd.cmd_ready) begin
            state       <= IDLE;
            offer_valid <= 1'b0;
            rr_ptr      <= offer_id + 2'd1;
          end
        end
        default: begin
          state       <= IDLE;
          offer_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_cmd_sched.sv
// tb/tb_button_cmd_sched.sv - self-checking bench for button_cmd_sched
module tb_button_cmd_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_pulse = 4'b0000;
  logic       vblank = 1'b0;
  logic [3:0] pending;
  logic [7:0] overrun_cnt;

  button_cmd_sched_if bif ();

  button_cmd_sched dut (
    .clk         (clk),
    .rst         (rst),
    .btn_pulse   (btn_pulse),
    .vblank      (vblank),
    .pending     (pending),
    .overrun_cnt (overrun_cnt),
    .cmd         (bif)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: per-button request flags, offer flag/id, next search start, lost-event total
  int m_pend [4] = '{0, 0, 0, 0};
  int m_offer = 0;
  int m_id    = 0;
  int m_rr    = 0;
  int m_ovr   = 0;

  int hs_count = 0;
  int hs_id    = 0;

  typedef struct {
    bit         rst;
    logic [3:0] btn;
    bit         vb;
    bit         rdy;
    int         ev;
    int         eid;
    int         epend;
    int         eovr;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(bit r, logic [3:0] b, bit v, bit rd);
    int lost;
    if (r) begin
      m_pend  = '{0, 0, 0, 0};
      m_offer = 0;
      m_id    = 0;
      m_rr    = 0;
      m_ovr   = 0;
      return;
    end
    if (m_offer != 0) begin
      if (rd) begin
        m_pend[m_id] = 0;
        m_rr         = (m_id + 1) % 4;
        m_offer      = 0;
      end
    end else if (v) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_rr + k) % 4;
        if (m_pend[j] != 0) begin
          m_offer = 1;
          m_id    = j;
          break;
        end
      end
    end
    lost = 0;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) begin
        if (m_pend[k] != 0) lost++;
        m_pend[k] = 1;
      end
    end
    m_ovr = (m_ovr + lost > 255) ? 255 : m_ovr + lost;
  endtask

  function automatic int model_pend();
    int p;
    p = 0;
    for (int k = 0; k < 4; k++) p += (m_pend[k] != 0) ? (1 << k) : 0;
    return p;
  endfunction

  // One clock: drive inputs, note any handshake, advance model, compare after the edge
  task automatic step(bit r, logic [3:0] b, bit v, bit rd);
    rst           = r;
    btn_pulse     = b;
    vblank        = v;
    bif.cmd_ready = rd;
    #1;
    if (bif.cmd_valid && rd && !r) begin
      hs_count++;
      hs_id = int'(bif.cmd_id);
    end
    model_step(r, b, v, rd);
    @(posedge clk);
    #1;
    chk("mdl_valid", int'(bif.cmd_valid), m_offer);
    chk("mdl_id", int'(bif.cmd_id), m_id);
    chk("mdl_pending", int'(pending), model_pend());
    chk("mdl_overrun", int'(overrun_cnt), m_ovr);
  endtask

  initial begin
    bif.cmd_ready = 1'b0;

    vecs[0]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 0, 0, 4'b0000, 0};
    vecs[1]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 0, 0, 4'b0100, 0};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1, 2, 4'b0100, 0};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 0, 2, 4'b0000, 0};
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 0, 2, 4'b0000, 0};
    vecs[5]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 0, 0, 4'b0000, 0};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 0, 0, 4'b1111, 0};
    vecs[7]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1, 0, 4'b1111, 0};
    vecs[8]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 0, 0, 4'b1110, 0};
    vecs[9]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1, 1, 4'b1110, 0};
    vecs[10] = '{1'b0, 4'b0000, 1'b1, 1'b1, 0, 1, 4'b1100, 0};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1, 2, 4'b1100, 0};
    vecs[12] = '{1'b0, 4'b0000, 1'b1, 1'b1, 0, 2, 4'b1000, 0};
    vecs[13] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1, 3, 4'b1000, 0};
    vecs[14] = '{1'b0, 4'b0000, 1'b1, 1'b1, 0, 3, 4'b0000, 0};

    @(posedge clk);
    #1;

    // Single-button latency and four-button round-robin drain, both from reset
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].btn, vecs[i].vb, vecs[i].rdy);
      chk($sformatf("tbl%0d_valid", i), int'(bif.cmd_valid), vecs[i].ev);
      chk($sformatf("tbl%0d_id", i), int'(bif.cmd_id), vecs[i].eid);
      chk($sformatf("tbl%0d_pending", i), int'(pending), vecs[i].epend);
      chk($sformatf("tbl%0d_overrun", i), int'(overrun_cnt), vecs[i].eovr);
    end

    // Gated accumulation: three pulses on button 1 outside vblank, then one command
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 4'b0010, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 4'b0010, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 4'b0010, 1'b0, 1'b1);
    chk("gate_hold_valid", int'(bif.cmd_valid), 0);
    chk("gate_overrun", int'(overrun_cnt), 2);
    hs_count = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, 1'b1, 1'b1);
    chk("gate_cmd_count", hs_count, 1);
    chk("gate_cmd_id", hs_id, 1);
    chk("gate_pending", int'(pending), 0);
    chk("gate_overrun_after", int'(overrun_cnt), 2);

    // Stall: offer of id 0 held for 10 cycles while vblank toggles and button 3 pulses
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    chk("stall_start_valid", int'(bif.cmd_valid), 1);
    chk("stall_start_id", int'(bif.cmd_id), 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, (i % 3 == 0) ? 4'b1000 : 4'b0000, (i % 2) == 1, 1'b0);
      chk($sformatf("stall%0d_valid", i), int'(bif.cmd_valid), 1);
      chk($sformatf("stall%0d_id", i), int'(bif.cmd_id), 0);
    end
    chk("stall_pending", int'(pending), 4'b1001);
    chk("stall_overrun", int'(overrun_cnt), 3);
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    chk("stall_gap_valid", int'(bif.cmd_valid), 0);
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    chk("stall_next_valid", int'(bif.cmd_valid), 1);
    chk("stall_next_id", int'(bif.cmd_id), 3);

    // Re-pulse of the button being accepted keeps it pending without an overrun
    step(1'b1, 4'b0000, 1'b1, 1'b1);
    step(1'b0, 4'b0100, 1'b1, 1'b1);
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    chk("repulse_offer_id", int'(bif.cmd_id), 2);
    step(1'b0, 4'b0100, 1'b1, 1'b1);
    chk("repulse_valid_gap", int'(bif.cmd_valid), 0);
    chk("repulse_pending", int'(pending), 4'b0100);
    chk("repulse_overrun", int'(overrun_cnt), 0);
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    chk("repulse_again_valid", int'(bif.cmd_valid), 1);
    chk("repulse_again_id", int'(bif.cmd_id), 2);

    // Reset aborts the live offer; then overrun counter saturates
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    chk("abort_valid", int'(bif.cmd_valid), 0);
    chk("abort_pending", int'(pending), 0);
    chk("abort_overrun", int'(overrun_cnt), 0);
    step(1'b0, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 1'b0);
    chk("sat_multi_add", int'(overrun_cnt), 4);
    for (int i = 0; i < 62; i++) step(1'b0, 4'b1111, 1'b0, 1'b0);
    chk("sat_252", int'(overrun_cnt), 252);
    step(1'b0, 4'b1111, 1'b0, 1'b0);
    chk("sat_clamp", int'(overrun_cnt), 255);
    for (int i = 0; i < 15; i++) step(1'b0, 4'b1111, 1'b0, 1'b0);
    chk("sat_hold", int'(overrun_cnt), 255);

    // Random traffic against the reference model
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] b;
      for (int k = 0; k < 4; k++) b[k] = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 99) == 0, b, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
